dual_port_mem_ctrl: RTL and testbench

DUAL_PORT_MEM_CTRL -- requirements
Module: dual_port_mem_ctrl

---
 rtl/dual_port_mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dual_port_mem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem_ctrl.sv
// Instruction-fetch and data ports sharing one byte-addressed array.
// Only one request is in flight; both ports are round-robin arbitrated with a fixed response latency.
module dual_port_mem_ctrl #(
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_req_addr,
    output logic        i_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] i_resp_instr,
    output logic        i_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_wr,
    input  logic [7:0]  d_req_strb,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_wdata,
    output logic        d_resp_valid,
    input  logic        d_resp_ready,
    output logic [63:0] d_resp_rdata,
    output logic        d_resp_err
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW1   = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_d;
    logic              req_d;
    logic              req_wr;
    logic [63:0]       req_addr;
    logic [7:0]        req_strb;
    logic [63:0]       req_wdata;
    logic [7:0]        mem [DEPTH];

    logic              grant_d_c;
    logic              grant_i_c;
    logic              accept_c;
    logic              enter_resp_c;
    logic              op_d_c;
    logic              op_wr_c;
    logic [63:0]       op_addr_c;
    logic [7:0]        op_strb_c;
    logic [63:0]       op_wdata_c;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W:0]   last_byte_c;
    logic              in_range_c;
    logic [63:0]       rd_bytes_c;
    logic [63:0]       rdata_c;
    logic [31:0]       instr_c;

    // Arbitration: when both ports request, the port that was not granted most recently wins.
    always_comb begin
        grant_d_c = 1'b0;
        grant_i_c = 1'b0;
        if (state == IDLE) begin
            if (d_req_valid && (!i_req_valid || !last_d)) begin
                grant_d_c = 1'b1;
            end else if (i_req_valid) begin
                grant_i_c = 1'b1;
            end
        end
    end

    assign d_req_ready  = grant_d_c;
    assign i_req_ready  = grant_i_c;
    assign accept_c     = grant_d_c || grant_i_c;
    assign enter_resp_c = ((state == IDLE) && accept_c && (LATENCY == 1)) ||
                          ((state == WAIT) && (cnt == CNT_W'(1)));

    // With LATENCY=1 the access happens on the accept edge, so it uses the request as it arrives.
    always_comb begin
        if (state == IDLE) begin
            op_d_c     = grant_d_c;
            op_wr_c    = grant_d_c && d_req_wr;
            op_addr_c  = grant_d_c ? d_req_addr : i_req_addr;
            op_strb_c  = d_req_strb;
            op_wdata_c = d_req_wdata;
        end else begin
            op_d_c     = req_d;
            op_wr_c    = req_wr;
            op_addr_c  = req_addr;
            op_strb_c  = req_strb;
            op_wdata_c = req_wdata;
        end
    end

    assign base_c      = op_addr_c[ADDR_W-1:0];
    assign last_byte_c = {1'b0, base_c} + (op_d_c ? AW1'(7) : AW1'(3));
    assign in_range_c  = (op_addr_c[63:ADDR_W] == '0) && (last_byte_c < MEM_BYTES);

    // Unaligned byte gather; the index wraps, but a wrapped access is out of range and its result is discarded.
    always_comb begin
        rd_bytes_c = '0;
        for (int i = 0; i < 8; i++) begin
            rd_bytes_c[8*i +: 8] = mem[base_c + ADDR_W'(i)];
        end
    end

    always_comb begin
        rdata_c = '0;
        instr_c = '0;
        if (in_range_c) begin
            if (op_d_c) begin
                if (!op_wr_c) begin
                    for (int i = 0; i < 8; i++) begin
                        if (op_strb_c[i]) begin
                            rdata_c[8*i +: 8] = rd_bytes_c[8*i +: 8];
                        end
                    end
                end
            end else begin
                instr_c = rd_bytes_c[31:0];
            end
        end
    end

    // The array is not reset; a write commits only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_c && op_d_c && op_wr_c && in_range_c) begin
            for (int i = 0; i < 8; i++) begin
                if (op_strb_c[i]) begin
                    mem[base_c + ADDR_W'(i)] <= op_wdata_c[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_d       <= 1'b0;
            req_d        <= 1'b0;
            req_wr       <= 1'b0;
            req_addr     <= '0;
            req_strb     <= '0;
            req_wdata    <= '0;
            i_resp_valid <= 1'b0;
            i_resp_instr <= '0;
            i_resp_err   <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_rdata <= '0;
            d_resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_d     <= op_d_c;
                        req_wr    <= op_wr_c;
                        req_addr  <= op_addr_c;
                        req_strb  <= op_strb_c;
                        req_wdata <= op_wdata_c;
                        last_d    <= grant_d_c;
                        state     <= WAIT;
                        cnt       <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                RESP: begin
                    if (req_d ? d_resp_ready : i_resp_ready) begin
                        state        <= IDLE;
                        i_resp_valid <= 1'b0;
                        i_resp_instr <= '0;
                        i_resp_err   <= 1'b0;
                        d_resp_valid <= 1'b0;
                        d_resp_rdata <= '0;
                        d_resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Entering RESP overrides the per-state updates above.
            if (enter_resp_c) begin
                state        <= RESP;
                cnt          <= '0;
                d_resp_valid <= op_d_c;
                d_resp_rdata <= rdata_c;
                d_resp_err   <= op_d_c && !in_range_c;
                i_resp_valid <= !op_d_c;
                i_resp_instr <= instr_c;
                i_resp_err   <= !op_d_c && !in_range_c;
            end
        end
    end
endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Scoreboard bench for dual_port_mem_ctrl: a byte-array model predicts grants and responses.
// A separate negedge monitor pops expectations and checks latency, payload and hold-stability.
module tb_dual_port_mem_ctrl;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LAT    = 3;
    localparam int unsigned MEM_N  = 1 << ADDR_W;
    localparam longint unsigned MEM   = 64'd1 << ADDR_W;
    localparam longint unsigned NEVER = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        bit              is_d;
        longint unsigned cyc;
        logic [63:0]     data;
        bit              err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
    logic [63:0] i_req_addr;
    logic [31:0] i_resp_instr;
    logic        d_req_valid, d_req_ready, d_req_wr, d_resp_valid, d_resp_ready, d_resp_err;
    logic [7:0]  d_req_strb;
    logic [63:0] d_req_addr, d_req_wdata, d_resp_rdata;

    int              tests = 0;
    int              failed = 0;
    longint unsigned cyc = 0;
    longint unsigned free_cycle = 0;
    bit              pref_d = 1'b1;
    bit              skip_model = 1'b0;
    bit              rand_rr = 1'b1;
    bit              acc_d, acc_i;
    bit              mon_act = 1'b0;
    exp_t            q[$];
    exp_t            cur;
    logic [7:0]      mdl [MEM_N];

    dual_port_mem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_instr(i_resp_instr), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wr(d_req_wr),
        .d_req_strb(d_req_strb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: an access is legal when all of its bytes lie inside the array.
    function automatic exp_t predict(input bit is_d, input logic [63:0] addr, input bit wr,
                                     input logic [7:0] strb, input logic [63:0] wdata);
        exp_t e;
        longint unsigned span;
        bit ok;
        span   = is_d ? 64'd8 : 64'd4;
        e.is_d = is_d;
        e.cyc  = cyc + LAT;
        e.data = '0;
        ok     = (addr <= MEM - span);
        e.err  = !ok;
        if (ok) begin
            for (int k = 0; k < int'(span); k++) begin
                if (!is_d || strb[k]) begin
                    if (is_d && wr) mdl[int'(addr) + k] = wdata[8*k +: 8];
                    else            e.data[8*k +: 8] = mdl[int'(addr) + k];
                end
            end
        end
        return e;
    endfunction

    // One clock: check grants at negedge, record accepts, then advance to just after the edge.
    task automatic cycle();
        bit ed, ei;
        @(negedge clk);
        acc_d = 1'b0;
        acc_i = 1'b0;
        if (!rst) begin
            ed = 1'b0;
            ei = 1'b0;
            if (cyc >= free_cycle) begin
                if (d_req_valid && (!i_req_valid || pref_d)) ed = 1'b1;
                else if (i_req_valid)                         ei = 1'b1;
            end
            chk("d_req_ready", 64'(d_req_ready), 64'(ed));
            chk("i_req_ready", 64'(i_req_ready), 64'(ei));
            acc_d = d_req_valid && d_req_ready;
            acc_i = i_req_valid && i_req_ready;
            if (acc_d || acc_i) begin
                pref_d     = !acc_d;
                free_cycle = NEVER;
                if (!skip_model) begin
                    if (acc_d) q.push_back(predict(1'b1, d_req_addr, d_req_wr, d_req_strb, d_req_wdata));
                    else       q.push_back(predict(1'b0, i_req_addr, 1'b0, 8'h00, 64'h0));
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_rr) begin
            i_resp_ready = ($urandom_range(0, 3) != 0);
            d_resp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        pref_d     = 1'b1;
        free_cycle = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_i_resp_valid"}, 64'(i_resp_valid), 64'd0);
        chk({tag, "_d_resp_valid"}, 64'(d_resp_valid), 64'd0);
        chk({tag, "_i_resp_err"},   64'(i_resp_err),   64'd0);
        chk({tag, "_d_resp_err"},   64'(d_resp_err),   64'd0);
        chk({tag, "_i_resp_instr"}, 64'(i_resp_instr), 64'd0);
        chk({tag, "_d_resp_rdata"}, d_resp_rdata,      64'd0);
    endtask

    task automatic issue_d(input bit wr, input logic [7:0] strb, input logic [63:0] addr,
                           input logic [63:0] wdata);
        bit got;
        got         = 1'b0;
        d_req_valid = 1'b1;
        d_req_wr    = wr;
        d_req_strb  = strb;
        d_req_addr  = addr;
        d_req_wdata = wdata;
        for (int n = 0; n < 60 && !got; n++) begin
            cycle();
            got = acc_d;
        end
        d_req_valid = 1'b0;
        chk("d_issue_accepted", 64'(got), 64'd1);
    endtask

    task automatic issue_i(input logic [63:0] addr);
        bit got;
        got         = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        for (int n = 0; n < 60 && !got; n++) begin
            cycle();
            got = acc_i;
        end
        i_req_valid = 1'b0;
        chk("i_issue_accepted", 64'(got), 64'd1);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return {$urandom, $urandom};
            1:       return 64'(MEM - 16 + 64'($urandom_range(0, 15)));
            default: return 64'($urandom_range(0, MEM_N - 1));
        endcase
    endfunction

    // Monitor: pop on the first cycle a response is shown, then check it every cycle until taken.
    always @(negedge clk) begin : monitor
        bit v, rdy;
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            v   = i_resp_valid || d_resp_valid;
            rdy = d_resp_valid ? d_resp_ready : i_resp_ready;
            chk("resp_valid_exclusive", 64'(i_resp_valid && d_resp_valid), 64'd0);
            if (v && !mon_act) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(v), 64'd0);
                end else begin
                    cur     = q.pop_front();
                    mon_act = 1'b1;
                    chk("resp_channel", 64'(d_resp_valid), 64'(cur.is_d));
                    chk("resp_latency", cyc, cur.cyc);
                end
            end else if (!v && mon_act) begin
                chk("resp_dropped", 64'(v), 64'd1);
                mon_act = 1'b0;
            end
            if (v && mon_act) begin
                if (cur.is_d) begin
                    chk("d_resp_rdata", d_resp_rdata, cur.data);
                    chk("d_resp_err", 64'(d_resp_err), 64'(cur.err));
                end else begin
                    chk("i_resp_instr", 64'(i_resp_instr), cur.data);
                    chk("i_resp_err", 64'(i_resp_err), 64'(cur.err));
                end
                if (rdy) begin
                    mon_act    = 1'b0;
                    free_cycle = cyc + 1;
                end
            end
            if (!mon_act && q.size() > 0 && cyc > q[0].cyc) begin
                chk("resp_late", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin : stimulus
        bit first_d;
        int seen;
        i_req_addr   = '0;
        d_req_wr     = 1'b0;
        d_req_strb   = '0;
        d_req_addr   = '0;
        d_req_wdata  = '0;
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        do_reset(3);
        chk_idle_outputs("reset");

        // Give every byte a known value.
        for (int a = 0; a < int'(MEM_N); a += 8) issue_d(1'b1, 8'hFF, 64'(a), {$urandom, $urandom});

        issue_d(1'b1, 8'hFF, 64'h100, 64'h1122334455667788);
        issue_d(1'b0, 8'h0F, 64'h100, 64'h0);

        issue_d(1'b1, 8'h81, 64'h203, {$urandom, $urandom});
        issue_d(1'b0, 8'hFF, 64'h200, 64'h0);
        issue_d(1'b0, 8'hFF, 64'h208, 64'h0);
        issue_i(64'h203);
        issue_d(1'b1, 8'h00, 64'h208, {$urandom, $urandom});
        issue_d(1'b0, 8'hFF, 64'h208, 64'h0);

        issue_i(64'(MEM - 2));
        issue_d(1'b1, 8'hFF, 64'h100 | (64'd1 << 40), {$urandom, $urandom});
        issue_d(1'b0, 8'hFF, 64'h100, 64'h0);
        issue_d(1'b0, 8'hFF, 64'(MEM - 8), 64'h0);
        issue_d(1'b0, 8'hFF, 64'(MEM - 7), 64'h0);

        // Simultaneous requests straight after reset: data goes first.
        do_reset(2);
        chk_idle_outputs("rearb");
        i_req_valid = 1'b1;
        i_req_addr  = 64'h41;
        d_req_valid = 1'b1;
        d_req_wr    = 1'b0;
        d_req_strb  = 8'hFF;
        d_req_addr  = 64'h80;
        first_d     = 1'b0;
        seen        = 0;
        for (int n = 0; n < 40 && (i_req_valid || d_req_valid); n++) begin
            cycle();
            if (acc_d || acc_i) begin
                if (seen == 0) first_d = acc_d;
                seen++;
            end
            if (acc_d) d_req_valid = 1'b0;
            if (acc_i) i_req_valid = 1'b0;
        end
        chk("grant_order_data_first", 64'(first_d), 64'd1);
        chk("both_granted", 64'(seen), 64'd2);

        // Back-pressure: response held for five cycles while a fetch waits.
        rand_rr      = 1'b0;
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b0;
        issue_d(1'b0, 8'hFF, 64'h123, 64'h0);
        i_req_valid = 1'b1;
        i_req_addr  = 64'h10;
        for (int n = 0; n < int'(LAT) + 4; n++) cycle();
        chk("held_d_resp_valid", 64'(d_resp_valid), 64'd1);
        d_resp_ready = 1'b1;
        issue_i(64'h10);
        rand_rr = 1'b1;

        // Reset one cycle after a write is accepted: the write must never land.
        do_reset(2);
        skip_model  = 1'b1;
        d_req_valid = 1'b1;
        d_req_wr    = 1'b1;
        d_req_strb  = 8'hFF;
        d_req_addr  = 64'h300;
        d_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        cycle();
        chk("abandoned_write_accepted", 64'(acc_d), 64'd1);
        d_req_valid = 1'b0;
        skip_model  = 1'b0;
        do_reset(1);
        chk_idle_outputs("midreset");
        issue_d(1'b0, 8'hFF, 64'h300, 64'h0);

        for (int n = 0; n < 2000; n++) begin
            i_req_valid = 1'($urandom_range(0, 1));
            i_req_addr  = rand_addr();
            d_req_valid = 1'($urandom_range(0, 1));
            d_req_wr    = 1'($urandom_range(0, 1));
            d_req_strb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d_req_addr  = rand_addr();
            d_req_wdata = {$urandom, $urandom};
            cycle();
        end

        i_req_valid  = 1'b0;
        d_req_valid  = 1'b0;
        rand_rr      = 1'b0;
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        for (int n = 0; n < 20 && (q.size() > 0 || mon_act); n++) cycle();
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("no_open_resp", 64'(mon_act), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
